dsp_lane_array: RTL and testbench

DSP_LANE_ARRAY -- requirements
Module: dsp_lane_array

---
 rtl/dsp_lane_array_if.sv | 27 ++
 rtl/dsp_lane_array.sv | 111 +++++++++++
 tb/tb_dsp_lane_array.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dsp_lane_array_if.sv
// Lane-array operand/result bundle: shared pipeline controls, per-lane operands and results.
// The master drives operands and controls; the slave (the array) returns results.
interface dsp_lane_array_if #(
  parameter int LANES = 16,
  parameter int AW    = 18,
  parameter int OW    = 37
);
  logic          dsp_ce;
  logic          in_valid;
  logic          signed_mode;
  logic          acc_en;
  logic          acc_clr;
  logic [AW-1:0] dsp_a0 [LANES];
  logic [AW-1:0] dsp_b0 [LANES];
  logic [OW-1:0] dsp_out [LANES];
  logic          out_valid;

  modport master (
    output dsp_ce, in_valid, signed_mode, acc_en, acc_clr, dsp_a0, dsp_b0,
    input  dsp_out, out_valid
  );

  modport slave (
    input  dsp_ce, in_valid, signed_mode, acc_en, acc_clr, dsp_a0, dsp_b0,
    output dsp_out, out_valid
  );
endinterface

// File: rtl/dsp_lane_array.sv
// LANES independent 3-stage multipliers (operands -> product -> result) under one clock enable.
// Define DSP_LANE_ACC_EN to build the per-lane accumulators driven by acc_en/acc_clr.
module dsp_lane_array #(
  parameter int LANES = 16,
  parameter int AW    = 18,
  parameter int OW    = 37
) (
  input  logic              clk,
  input  logic              rst_n,
  dsp_lane_array_if.slave   bus
);
  localparam int PW = 2 * AW;

  // S1: operands and the controls that travel with them
  logic [AW-1:0] a_q [LANES];
  logic [AW-1:0] b_q [LANES];
  logic          s1_vld_q;
  logic          s1_sgn_q;
  // S2: raw product
  logic [PW-1:0] p_q [LANES];
  logic          s2_vld_q;
  logic          s2_sgn_q;
  // S3: lane results
  logic [OW-1:0] out_q [LANES];
  logic          out_vld_q;

  logic [PW-1:0] prod_d [LANES];
  logic [OW-1:0] ext_d  [LANES];

`ifdef DSP_LANE_ACC_EN
  logic          s1_acc_q;
  logic          s2_acc_q;
`else
  logic          unused_ctl;
  assign unused_ctl = ^{bus.acc_en, bus.acc_clr};
`endif

  // Extending both operands to PW bits makes one unsigned multiplier serve both modes:
  // the low PW bits of the product are identical for signed and unsigned operands.
  // NOTE: every always_comb output is assigned on every path, so no latch can be inferred.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      prod_d[i] = {{AW{s1_sgn_q & a_q[i][AW-1]}}, a_q[i]} *
                  {{AW{s1_sgn_q & b_q[i][AW-1]}}, b_q[i]};
      ext_d[i]  = {{(OW-PW){s2_sgn_q & p_q[i][PW-1]}}, p_q[i]};
    end
  end

  // NOTE: state uses non-blocking assignments; these arrays are pipeline registers, not
  // a RAM, so resetting every entry is intended.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LANES; i++) begin
        a_q[i]   <= '0;
        b_q[i]   <= '0;
        p_q[i]   <= '0;
        out_q[i] <= '0;
      end
      s1_vld_q  <= 1'b0;
      s1_sgn_q  <= 1'b0;
      s2_vld_q  <= 1'b0;
      s2_sgn_q  <= 1'b0;
      out_vld_q <= 1'b0;
`ifdef DSP_LANE_ACC_EN
      s1_acc_q  <= 1'b0;
      s2_acc_q  <= 1'b0;
`endif
    end else begin
      if (bus.dsp_ce) begin
        for (int i = 0; i < LANES; i++) begin
          a_q[i] <= bus.dsp_a0[i];
          b_q[i] <= bus.dsp_b0[i];
          p_q[i] <= prod_d[i];
        end
        s1_vld_q  <= bus.in_valid;
        s1_sgn_q  <= bus.signed_mode;
        s2_vld_q  <= s1_vld_q;
        s2_sgn_q  <= s1_sgn_q;
        out_vld_q <= s2_vld_q;
`ifdef DSP_LANE_ACC_EN
        s1_acc_q  <= bus.acc_en;
        s2_acc_q  <= s1_acc_q;
`endif
      end
`ifdef DSP_LANE_ACC_EN
      else if (bus.acc_clr) begin
        out_vld_q <= 1'b0;
      end
`endif

      // A clear that coincides with a load yields the fresh product, never old + product.
      for (int i = 0; i < LANES; i++) begin
`ifdef DSP_LANE_ACC_EN
        if (bus.dsp_ce && s2_vld_q) begin
          out_q[i] <= (s2_acc_q && !bus.acc_clr) ? out_q[i] + ext_d[i] : ext_d[i];
        end else if (bus.acc_clr) begin
          out_q[i] <= '0;
        end
`else
        if (bus.dsp_ce && s2_vld_q) begin
          out_q[i] <= ext_d[i];
        end
`endif
      end
    end
  end

  // A held result is only reported on an enabled cycle.
  assign bus.out_valid = out_vld_q & bus.dsp_ce;
  assign bus.dsp_out   = out_q;
endmodule

// File: tb/tb_dsp_lane_array.sv
// Directed bench for dsp_lane_array: a beat-queue reference model checked every cycle,
// plus hand-computed literal expectations for the key scenarios.
module tb_dsp_lane_array;
  localparam int LANES = 16;
  localparam int AW    = 18;
  localparam int OW    = 37;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  dsp_lane_array_if #(.LANES(LANES), .AW(AW), .OW(OW)) bus ();
  dsp_lane_array #(.LANES(LANES), .AW(AW), .OW(OW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  typedef struct {
    bit            valid;
    bit            sgn;
    bit            acc;
    logic [AW-1:0] a [LANES];
    logic [AW-1:0] b [LANES];
    int unsigned   due;
  } beat_t;

  // Reference model: every captured beat lands on the second enabled edge after capture.
  beat_t         q[$];
  logic [OW-1:0] m_out [LANES];
  bit            m_vld;
  int unsigned   m_edges = 0;

  task automatic check(string name, logic [OW-1:0] got, logic [OW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [OW-1:0] prod(bit sgn, logic [AW-1:0] a, logic [AW-1:0] b);
    longint x, y;
    if (sgn) begin
      x = longint'($signed(a));
      y = longint'($signed(b));
    end else begin
      x = longint'(a);
      y = longint'(b);
    end
    return OW'(x * y);
  endfunction

  task automatic model_reset();
    q.delete();
    for (int i = 0; i < LANES; i++) m_out[i] = '0;
    m_vld = 1'b0;
  endtask

  // Compute what the coming edge must do from the inputs now applied, then clock it in.
  task automatic cycle();
    logic [OW-1:0] nxt [LANES];
    logic [OW-1:0] base;
    bit            nvld;
    bit            loaded;
    beat_t         cur;
    beat_t         old;
    nxt    = m_out;
    nvld   = m_vld;
    loaded = 1'b0;
    if (bus.dsp_ce) begin
      nvld = 1'b0;
      if (q.size() != 0 && q[0].due == m_edges + 1) begin
        old = q.pop_front();
        if (old.valid) begin
          loaded = 1'b1;
          nvld   = 1'b1;
          for (int i = 0; i < LANES; i++) begin
            base = '0;
`ifdef DSP_LANE_ACC_EN
            if (old.acc && !bus.acc_clr) base = m_out[i];
`endif
            nxt[i] = base + prod(old.sgn, old.a[i], old.b[i]);
          end
        end
      end
      cur.valid = bus.in_valid;
      cur.sgn   = bus.signed_mode;
      cur.acc   = bus.acc_en;
      for (int i = 0; i < LANES; i++) begin
        cur.a[i] = bus.dsp_a0[i];
        cur.b[i] = bus.dsp_b0[i];
      end
      cur.due = m_edges + 3;
      q.push_back(cur);
      m_edges++;
    end
`ifdef DSP_LANE_ACC_EN
    if (bus.acc_clr && !loaded) begin
      for (int i = 0; i < LANES; i++) nxt[i] = '0;
      nvld = 1'b0;
    end
`endif
    @(posedge clk);
    m_out = nxt;
    m_vld = nvld;
    #1;
  endtask

  task automatic set_all(logic [AW-1:0] a, logic [AW-1:0] b);
    for (int i = 0; i < LANES; i++) begin
      bus.dsp_a0[i] = a;
      bus.dsp_b0[i] = b;
    end
  endtask

  // Per-cycle comparison against the model, on the falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("out_valid", OW'(bus.out_valid), OW'(m_vld & bus.dsp_ce));
      for (int i = 0; i < LANES; i++)
        check($sformatf("dsp_out[%0d]", i), bus.dsp_out[i], m_out[i]);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, got no finish expected finish");
    $fatal(1, "time limit");
  end

  initial begin
    rst_n           = 1'b0;
    bus.dsp_ce      = 1'b1;
    bus.in_valid    = 1'b0;
    bus.signed_mode = 1'b0;
    bus.acc_en      = 1'b0;
    bus.acc_clr     = 1'b0;
    set_all('0, '0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;
    check("reset out_valid", OW'(bus.out_valid), '0);
    check("reset dsp_out[0]", bus.dsp_out[0], '0);
    rst_n = 1'b1;
    cycle();

    // Unsigned beat, boundary operand on lane 15, distinct data on the other lanes
    for (int i = 1; i < LANES - 1; i++) begin
      bus.dsp_a0[i] = AW'(i * 1000 + 7);
      bus.dsp_b0[i] = AW'(18'h3FFFF - i);
    end
    bus.dsp_a0[0] = 18'd255;      bus.dsp_b0[0] = 18'd255;
    bus.dsp_a0[15] = 18'h3FFFF;   bus.dsp_b0[15] = 18'd1;
    bus.in_valid = 1'b1;
    cycle();
    bus.in_valid = 1'b0;
    cycle();
    check("latency out_valid early", OW'(bus.out_valid), '0);
    cycle();
    check("unsigned lane0", bus.dsp_out[0], 37'd65025);
    check("unsigned lane15", bus.dsp_out[15], 37'd262143);
    check("unsigned out_valid", OW'(bus.out_valid), 37'd1);
    cycle();
    check("out_valid pulse end", OW'(bus.out_valid), '0);

    // Signed beat
    for (int i = 2; i < LANES; i++) begin
      bus.dsp_a0[i] = AW'(18'h20000 + i * 511);
      bus.dsp_b0[i] = AW'(i * 37);
    end
    bus.dsp_a0[0] = 18'h3FFFF;  bus.dsp_b0[0] = 18'd2;
    bus.dsp_a0[1] = 18'h20000;  bus.dsp_b0[1] = 18'h20000;
    bus.signed_mode = 1'b1;
    bus.in_valid    = 1'b1;
    cycle();
    bus.in_valid    = 1'b0;
    bus.signed_mode = 1'b0;
    cycle();
    cycle();
    check("signed -1*2", bus.dsp_out[0], 37'h1FFFFFFFFE);
    check("signed min*min", bus.dsp_out[1], 37'h0400000000);

    // Stall at S2 for two cycles
    set_all(18'd7, 18'd9);
    bus.in_valid = 1'b1;
    cycle();
    bus.in_valid = 1'b0;
    cycle();
    bus.dsp_ce = 1'b0;
    cycle();
    check("stall out_valid a", OW'(bus.out_valid), '0);
    check("stall holds lane0", bus.dsp_out[0], 37'h1FFFFFFFFE);
    cycle();
    check("stall out_valid b", OW'(bus.out_valid), '0);
    bus.dsp_ce = 1'b1;
    cycle();
    check("stall result", bus.dsp_out[0], 37'd63);
    check("stall out_valid", OW'(bus.out_valid), 37'd1);
    bus.dsp_ce = 1'b0;
    cycle();
    bus.dsp_ce = 1'b1;
    cycle();

    // Invalid beat between two valid beats
    set_all(18'd2, 18'd3);
    bus.in_valid = 1'b1;
    cycle();
    set_all(18'd100, 18'd100);
    bus.in_valid = 1'b0;
    cycle();
    set_all(18'd5, 18'd5);
    bus.in_valid = 1'b1;
    cycle();
    bus.in_valid = 1'b0;
    set_all(18'd0, 18'd0);
    check("gap first beat", bus.dsp_out[3], 37'd6);
    cycle();
    check("gap invalid beat", bus.dsp_out[3], 37'd6);
    check("gap invalid out_valid", OW'(bus.out_valid), '0);
    cycle();
    check("gap second beat", bus.dsp_out[3], 37'd25);

    // Reset with two beats in flight
    set_all(18'd11, 18'd13);
    bus.in_valid = 1'b1;
    cycle();
    cycle();
    bus.in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("async reset out_valid", OW'(bus.out_valid), '0);
    check("async reset dsp_out[3]", bus.dsp_out[3], '0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (4) cycle();
    check("post reset dsp_out[0]", bus.dsp_out[0], '0);

`ifdef DSP_LANE_ACC_EN
    bus.acc_clr = 1'b1;
    cycle();
    bus.acc_clr = 1'b0;
    set_all(18'd3, 18'd4);
    bus.acc_en   = 1'b1;
    bus.in_valid = 1'b1;
    repeat (4) cycle();
    bus.in_valid = 1'b0;
    cycle();
    cycle();
    check("acc four beats", bus.dsp_out[0], 37'd48);
    bus.in_valid = 1'b1;
    cycle();
    bus.in_valid = 1'b0;
    cycle();
    bus.acc_clr = 1'b1;
    cycle();
    bus.acc_clr = 1'b0;
    check("acc clear with load", bus.dsp_out[0], 37'd12);
    check("acc clear with load valid", OW'(bus.out_valid), 37'd1);
    bus.dsp_ce  = 1'b0;
    bus.acc_clr = 1'b1;
    cycle();
    bus.acc_clr = 1'b0;
    check("acc clear while stalled", bus.dsp_out[5], '0);
    bus.dsp_ce = 1'b1;
    set_all(18'h3FFFF, 18'd1);
    bus.signed_mode = 1'b1;
    bus.in_valid    = 1'b1;
    cycle();
    cycle();
    bus.in_valid    = 1'b0;
    bus.signed_mode = 1'b0;
    cycle();
    cycle();
    check("acc wrap", bus.dsp_out[0], 37'h1FFFFFFFFE);
    bus.acc_en = 1'b0;
`else
    set_all(18'd3, 18'd4);
    bus.acc_en   = 1'b1;
    bus.in_valid = 1'b1;
    cycle();
    cycle();
    bus.in_valid = 1'b0;
    bus.acc_clr  = 1'b1;
    repeat (3) cycle();
    bus.acc_clr = 1'b0;
    bus.acc_en  = 1'b0;
    check("acc ignored", bus.dsp_out[0], 37'd12);
`endif
    cycle();
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
